// File: rtl/data_mem_responder_if.sv
// CPU-side access bus of the data memory responder.
// Signal names keep the block's established _i/_o naming.
interface data_mem_responder_if;
   logic        req_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        ack_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        busy_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  ack_o, rdata_o, err_o, busy_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output ack_o, rdata_o, err_o, busy_o
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data store answering one CPU access at a time after WAIT wait states,
// reporting misaligned or out-of-range accesses as faults.
module data_mem_responder #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned WAIT  = 2
) (
   input logic                 clk_i,
   input logic                 rst_n,
   data_mem_responder_if.slave bus
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]    stateQ, stateD;
   logic [3:0]    cntQ, cntD;
   logic          weQ;
   logic [31:0]   addrQ, wdataQ;
   logic          accept, enterResp;
   logic          curWe;
   logic [31:0]   curAddr, curWdata;
   logic          fault;
   logic [AW-1:0] wordIdx;
   logic          ackQ, errQ;
   logic [31:0]   rdataQ;
   logic [31:0]   mem [DEPTH];

   // With no wait states the access completes on its accept edge, so use the live inputs.
   assign curWe    = (WAIT == 0) ? bus.we_i    : weQ;
   assign curAddr  = (WAIT == 0) ? bus.addr_i  : addrQ;
   assign curWdata = (WAIT == 0) ? bus.wdata_i : wdataQ;

   assign wordIdx = curAddr[2 +: AW];
   assign fault   = (curAddr[1:0] != 2'b00) || ({2'b00, curAddr[31:2]} >= DEPTH);

   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      accept    = 1'b0;
      enterResp = 1'b0;
      case (stateQ)
         // The edge that ends the ack cycle may already take the next request.
         StIdle, StResp: begin
            if (bus.req_i) begin
               accept = 1'b1;
            end else begin
               stateD = StIdle;
            end
         end
         StWait: begin
            if (cntQ == 4'd1) begin
               enterResp = 1'b1;
               stateD    = StResp;
               cntD      = 4'd0;
            end else begin
               cntD = cntQ - 4'd1;
            end
         end
         default: stateD = StIdle;
      endcase
      if (accept) begin
         if (WAIT == 0) begin
            stateD    = StResp;
            enterResp = 1'b1;
         end else begin
            stateD = StWait;
            cntD   = 4'(WAIT);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= StIdle;
         cntQ   <= 4'd0;
         weQ    <= 1'b0;
         addrQ  <= '0;
         wdataQ <= '0;
         ackQ   <= 1'b0;
         errQ   <= 1'b0;
         rdataQ <= '0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
         if (accept) begin
            weQ    <= bus.we_i;
            addrQ  <= bus.addr_i;
            wdataQ <= bus.wdata_i;
         end
         ackQ   <= enterResp;
         errQ   <= enterResp & fault;
         rdataQ <= (enterResp && !fault && !curWe) ? mem[wordIdx] : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (enterResp && curWe && !fault) begin
         mem[wordIdx] <= curWdata;
      end
   end

   assign bus.ack_o   = ackQ;
   assign bus.err_o   = errQ;
   assign bus.rdata_o = rdataQ;
   assign bus.busy_o  = (stateQ != StIdle);
endmodule

// File: tb/tb_data_mem_responder.sv
// Scenario bench for data_mem_responder: a WAIT=2 instance and a WAIT=0 instance,
// expected responses queued at issue time and popped when ack_o appears.
module tb_data_mem_responder;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;
   int   edgeCnt    = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] model [128];

   data_mem_responder_if busA ();
   data_mem_responder_if busZ ();

   data_mem_responder #(.DEPTH(128), .WAIT(2)) dutA (.clk_i(clk), .rst_n(rst_n), .bus(busA));
   data_mem_responder #(.DEPTH(128), .WAIT(0)) dutZ (.clk_i(clk), .rst_n(rst_n), .bus(busZ));

   always #5 clk = ~clk;
   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   task automatic pushExp(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      logic bad;
      bad     = (addr[1:0] != 2'b00) || (addr >= 32'd512);
      e.err   = bad;
      e.rdata = (bad || we) ? 32'h0 : model[addr[8:2]];
      if (!bad && we) model[addr[8:2]] = wdata;
      sbq.push_back(e);
   endtask

   // Issue one access on busA, drop req after the accept edge, and report the response.
   task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic got, output int lat, output logic [31:0] rd,
                           output logic err, output logic ackNext);
      int aEdge;
      @(negedge clk);
      busA.req_i = 1'b1; busA.we_i = we; busA.addr_i = addr; busA.wdata_i = wdata;
      pushExp(we, addr, wdata);
      aEdge = edgeCnt + 1;
      @(negedge clk);
      busA.req_i = 1'b0;
      got = 1'b0; lat = -1; rd = 'x; err = 1'bx; ackNext = 1'bx;
      for (int i = 0; i < 8 && !got; i++) begin
         if (busA.ack_o) begin
            got = 1'b1; lat = edgeCnt - aEdge; rd = busA.rdata_o; err = busA.err_o;
         end else begin
            @(negedge clk);
         end
      end
      if (got) begin
         @(negedge clk);
         ackNext = busA.ack_o;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      compared++;
      if ({busA.ack_o, busA.err_o, busA.busy_o} !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_a_flags: got %b want 000", {busA.ack_o, busA.err_o, busA.busy_o});
      end
      compared++;
      if (busA.rdata_o !== 32'h0) begin
         mismatched++; $display("FAIL reset_a_rdata: got %h want 00000000", busA.rdata_o);
      end
      compared++;
      if ({busZ.ack_o, busZ.err_o, busZ.busy_o} !== 3'b000) begin
         mismatched++;
         $display("FAIL reset_z_flags: got %b want 000", {busZ.ack_o, busZ.err_o, busZ.busy_o});
      end
   endtask

   // Release reset and request in the same cycle: the first rising edge must accept.
   task automatic test_zero_wait();
      exp_t e;
      @(negedge clk);
      rst_n = 1'b1;
      busZ.req_i = 1'b1; busZ.we_i = 1'b0; busZ.addr_i = 32'h0; busZ.wdata_i = 32'h0;
      pushExp(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      busZ.req_i = 1'b0;
      compared++;
      if (busZ.ack_o !== 1'b1) begin
         mismatched++; $display("FAIL zw_ack: got %b want 1", busZ.ack_o);
      end
      e = sbq.pop_front();
      compared++;
      if (busZ.rdata_o !== e.rdata || busZ.err_o !== e.err) begin
         mismatched++;
         $display("FAIL zw_data: got %h/%b want %h/%b", busZ.rdata_o, busZ.err_o, e.rdata, e.err);
      end
      compared++;
      if (busZ.busy_o !== 1'b1) begin
         mismatched++; $display("FAIL zw_busy_ack: got %b want 1", busZ.busy_o);
      end
      @(negedge clk);
      compared++;
      if ({busZ.ack_o, busZ.busy_o, busZ.err_o} !== 3'b000 || busZ.rdata_o !== 32'h0) begin
         mismatched++;
         $display("FAIL zw_after: got ack/busy/err %b rdata %h want 000/00000000",
                  {busZ.ack_o, busZ.busy_o, busZ.err_o}, busZ.rdata_o);
      end
   endtask

   task automatic test_write_read();
      logic got, err, ackNext;
      int lat;
      logic [31:0] rd;
      exp_t e;
      logic        weT [2];
      logic [31:0] adT [2];
      weT[0] = 1'b1; adT[0] = 32'h10;
      weT[1] = 1'b0; adT[1] = 32'h10;
      for (int i = 0; i < 2; i++) begin
         transact(weT[i], adT[i], 32'hDEAD_BEEF, got, lat, rd, err, ackNext);
         e = sbq.pop_front();
         compared++;
         if (got !== 1'b1 || lat != 2) begin
            mismatched++; $display("FAIL wr_timing[%0d]: got ack %b lat %0d want 1 lat 2", i, got, lat);
         end
         compared++;
         if (rd !== e.rdata || err !== e.err) begin
            mismatched++;
            $display("FAIL wr_data[%0d]: got %h/%b want %h/%b", i, rd, err, e.rdata, e.err);
         end
         compared++;
         if (ackNext !== 1'b0) begin
            mismatched++; $display("FAIL wr_ack_len[%0d]: got %b want 0", i, ackNext);
         end
      end
   endtask

   task automatic test_faults();
      logic got, err, ackNext;
      int lat;
      logic [31:0] rd;
      exp_t e;
      logic        weT [4];
      logic [31:0] adT [4];
      weT[0] = 1'b1; adT[0] = 32'h0;
      weT[1] = 1'b0; adT[1] = 32'h2;
      weT[2] = 1'b1; adT[2] = 32'h200;
      weT[3] = 1'b0; adT[3] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         transact(weT[i], adT[i], (i == 0) ? 32'hCAFE_0001 : 32'h0000_1234,
                  got, lat, rd, err, ackNext);
         e = sbq.pop_front();
         compared++;
         if (got !== 1'b1 || rd !== e.rdata || err !== e.err) begin
            mismatched++;
            $display("FAIL fault[%0d]: got ack %b %h/%b want 1 %h/%b", i, got, rd, err, e.rdata, e.err);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic got, err, ackNext;
      int lat, ackCount;
      logic [31:0] rd, rdAck;
      logic errAck;
      exp_t e;
      transact(1'b1, 32'h4, 32'h77, got, lat, rd, err, ackNext);
      void'(sbq.pop_front());
      @(negedge clk);
      busA.req_i = 1'b1; busA.we_i = 1'b0; busA.addr_i = 32'h8; busA.wdata_i = 32'h0;
      pushExp(1'b0, 32'h8, 32'h0);
      @(negedge clk);
      busA.we_i = 1'b1; busA.addr_i = 32'h4; busA.wdata_i = 32'h1;
      @(negedge clk);
      busA.req_i = 1'b0;
      ackCount = (busA.ack_o === 1'b1) ? 1 : 0;
      rdAck = busA.rdata_o; errAck = busA.err_o;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (busA.ack_o === 1'b1) begin
            ackCount++; rdAck = busA.rdata_o; errAck = busA.err_o;
         end
      end
      e = sbq.pop_front();
      compared++;
      if (ackCount != 1) begin
         mismatched++; $display("FAIL busy_ack_count: got %0d want 1", ackCount);
      end
      compared++;
      if (rdAck !== e.rdata || errAck !== e.err) begin
         mismatched++;
         $display("FAIL busy_read: got %h/%b want %h/%b", rdAck, errAck, e.rdata, e.err);
      end
      transact(1'b0, 32'h4, 32'h0, got, lat, rd, err, ackNext);
      e = sbq.pop_front();
      compared++;
      if (got !== 1'b1 || rd !== e.rdata) begin
         mismatched++; $display("FAIL busy_word1: got %b %h want 1 %h", got, rd, e.rdata);
      end
   endtask

   task automatic test_back_to_back();
      int aEdge, consec, rdBad;
      int ackOffs[$];
      logic prev;
      exp_t e;
      @(negedge clk);
      busA.req_i = 1'b1; busA.we_i = 1'b0; busA.addr_i = 32'h0; busA.wdata_i = 32'h0;
      for (int i = 0; i < 3; i++) pushExp(1'b0, 32'h0, 32'h0);
      aEdge = edgeCnt + 1;
      prev = 1'b0; consec = 0; rdBad = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (i == 7) busA.req_i = 1'b0;
         if (busA.ack_o === 1'b1) begin
            ackOffs.push_back(edgeCnt - aEdge);
            if (prev) consec++;
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               if (busA.rdata_o !== e.rdata || busA.err_o !== e.err) rdBad++;
            end else begin
               rdBad++;
            end
         end
         prev = busA.ack_o;
      end
      compared++;
      if (ackOffs.size() != 3) begin
         mismatched++; $display("FAIL b2b_ack_count: got %0d want 3", ackOffs.size());
      end else begin
         compared++;
         if (ackOffs[0] != 2 || ackOffs[1] != 5 || ackOffs[2] != 8) begin
            mismatched++;
            $display("FAIL b2b_ack_edges: got %0d,%0d,%0d want 2,5,8",
                     ackOffs[0], ackOffs[1], ackOffs[2]);
         end
      end
      compared++;
      if (consec != 0) begin
         mismatched++; $display("FAIL b2b_consecutive: got %0d want 0", consec);
      end
      compared++;
      if (rdBad != 0) begin
         mismatched++; $display("FAIL b2b_rdata: got %0d bad want 0", rdBad);
      end
      compared++;
      if (busA.busy_o !== 1'b0) begin
         mismatched++; $display("FAIL b2b_idle: got %b want 0", busA.busy_o);
      end
      sbq.delete();
   endtask

   task automatic test_reset_mid_write();
      logic got, err, ackNext;
      int lat, ackCount;
      logic [31:0] rd;
      exp_t e;
      @(negedge clk);
      busA.req_i = 1'b1; busA.we_i = 1'b1; busA.addr_i = 32'hC; busA.wdata_i = 32'h55;
      @(negedge clk);
      busA.req_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if ({busA.ack_o, busA.err_o, busA.busy_o} !== 3'b000 || busA.rdata_o !== 32'h0) begin
         mismatched++;
         $display("FAIL rst_mid_outputs: got %b/%h want 000/00000000",
                  {busA.ack_o, busA.err_o, busA.busy_o}, busA.rdata_o);
      end
      for (int i = 0; i < 128; i++) model[i] = 32'h0;
      sbq.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ackCount = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (busA.ack_o === 1'b1) ackCount++;
      end
      compared++;
      if (ackCount != 0) begin
         mismatched++; $display("FAIL rst_mid_no_ack: got %0d want 0", ackCount);
      end
      transact(1'b0, 32'hC, 32'h0, got, lat, rd, err, ackNext);
      e = sbq.pop_front();
      compared++;
      if (got !== 1'b1 || rd !== e.rdata || err !== e.err) begin
         mismatched++;
         $display("FAIL rst_mid_read: got %b %h/%b want 1 %h/%b", got, rd, err, e.rdata, e.err);
      end
   endtask

   initial begin
      busA.req_i = 1'b0; busA.we_i = 1'b0; busA.addr_i = '0; busA.wdata_i = '0;
      busZ.req_i = 1'b0; busZ.we_i = 1'b0; busZ.addr_i = '0; busZ.wdata_i = '0;
      for (int i = 0; i < 128; i++) model[i] = 32'h0;
      test_reset();
      test_zero_wait();
      test_write_read();
      test_faults();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128, number of 32-bit words in the store.
REQ-002 SHALL have parameter WAIT, default 2, wait-state cycles per access (legal 0..15).
REQ-003 SHALL have port clk_i  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  1  access request from the CPU side.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read; sampled with req_i.
REQ-007 SHALL have port addr_i  input  32  byte address; sampled with req_i.
REQ-008 SHALL have port wdata_i  input  32  write data; sampled with req_i.
REQ-009 SHALL have port ack_o  output  1  one-cycle response strobe.
REQ-010 SHALL have port rdata_o  output  32  read data, valid only while ack_o=1.
REQ-011 SHALL have port err_o  output  1  access fault, valid only while ack_o=1.
REQ-012 SHALL have port busy_o  output  1  1 whenever the block is not in IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 SHALL accept a request on edge A when state=IDLE and req_i=1: capture we_i, addr_i and wdata_i; go to WAIT with cnt=WAIT, or straight to RESP if WAIT=0.
REQ-015 SHALL, in WAIT, go to RESP on the edge where cnt==1; otherwise decrement cnt.
REQ-016 SHALL drive ack_o=1 for exactly one cycle, from edge A+WAIT to edge A+WAIT+1, and then return to IDLE unconditionally.
REQ-017 SHALL ignore req_i in WAIT and RESP; the earliest next accept is the edge ending the ack cycle.
REQ-018 SHALL treat req_i still high in IDLE, including right after RESP, as a new request; the requester drops req_i during the ack cycle.
REQ-019 SHALL flag a fault when captured addr[1:0]!=0 or addr[31:2]>=DEPTH.
REQ-020 SHALL, for a faulting access, set err_o=1 and rdata_o=0 in the ack cycle and leave the store unchanged.
REQ-021 SHALL, for a good write, update word addr[31:2] on the edge entering RESP, with rdata_o=0 and err_o=0 in the ack cycle.
REQ-022 SHALL, for a good read, present the word at addr[31:2] on rdata_o, registered on the edge entering RESP, with err_o=0.
REQ-023 SHALL hold rdata_o=0 and err_o=0 whenever ack_o=0.
REQ-024 SHALL return a read of a word written by the previous transaction with the new value.
REQ-025 SHALL register all outputs; busy_o SHALL be decoded from registered state.

Reset
REQ-026 SHALL, when rst_n=0, immediately force state=IDLE, cnt=0, ack_o=0, err_o=0, rdata_o=0 and busy_o=0.
REQ-027 SHALL clear every store word to 0 while rst_n=0.
REQ-028 SHALL discard an in-flight transaction on reset, including a write not yet committed; no ack_o is produced for it.
REQ-029 SHALL accept a new request on the first rising edge with rst_n=1.

Verification
REQ-030 Write/read, WAIT=2: write 0x0000_0010 <- 0xDEAD_BEEF, accepted at edge 0 -> ack_o high edge 2..3, err_o=0; then read 0x10 -> ack with rdata_o=0xDEAD_BEEF.
REQ-031 Zero wait, WAIT=0: read 0x0 after reset -> ack_o high edge A..A+1 with rdata_o=0x0; busy_o high only in that cycle.
REQ-032 Faults: read 0x0000_0002 -> err_o=1, rdata_o=0; write 0x0000_0200 (word 128, DEPTH=128) -> err_o=1; a later read of word 0 still returns its prior value.
REQ-033 Busy ignore: req_i pulsed with write 0x4 <- 0x1 during WAIT of a read of 0x8 -> one ack only, and word 1 is unchanged.
REQ-034 Held request: req_i held high for 8 cycles, WAIT=2, read 0x0 -> ack pulses 3 cycles apart (accept at edges 0 and 3), never two consecutive ack cycles.
REQ-035 Reset mid-write: rst_n low during WAIT of write 0xC <- 0x55 -> outputs 0 at once and no ack; after release, read 0xC returns 0x0.
